// File: rtl/mul_sequencer_if.sv
// Request bus between decode and the multiply sequencer: funct-coded requests in,
// MFHI/MFLO read data out.
interface mul_sequencer_if #(
  parameter int OP_W = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [5:0]      Signal;
  logic [OP_W-1:0] dataA;
  logic [OP_W-1:0] dataB;
  logic [OP_W-1:0] dataOut;
  logic            out_valid;

  modport master (
    output req_valid, Signal, dataA, dataB,
    input  req_ready, dataOut, out_valid
  );

  modport slave (
    input  req_valid, Signal, dataA, dataB,
    output req_ready, dataOut, out_valid
  );
endinterface

// File: rtl/mul_sequencer.sv
// Sequences an external shift-add multiplier and owns the HI/LO pair.
// Optional signed multiply (F_MULT) is enabled by defining MUL_SIGNED_EN.
module mul_sequencer #(
  parameter int         OP_W    = 32,
  parameter logic [5:0] F_MULTU = 6'd25,
  parameter logic [5:0] F_MULT  = 6'd24,
  parameter logic [5:0] F_MFHI  = 6'd16,
  parameter logic [5:0] F_MFLO  = 6'd18
) (
  input  logic              clk,
  input  logic              reset,
  mul_sequencer_if.slave    req,
  output logic              mul_load,
  output logic              mul_step,
  output logic [OP_W-1:0]   mul_opA,
  output logic [OP_W-1:0]   mul_opB,
  input  logic [2*OP_W-1:0] mul_product,
  output logic              busy
);

  localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WRITE} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0] hi;
  logic [OP_W-1:0] lo;

`ifdef MUL_SIGNED_EN
  logic sgn;
  logic [OP_W-1:0] mag_a;
  logic [OP_W-1:0] mag_b;

  // Two's-complement magnitude; the most negative value maps to 2^(OP_W-1) unsigned.
  assign mag_a = req.dataA[OP_W-1] ? (~req.dataA + 1'b1) : req.dataA;
  assign mag_b = req.dataB[OP_W-1] ? (~req.dataB + 1'b1) : req.dataB;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hi            <= '0;
      lo            <= '0;
      mul_opA       <= '0;
      mul_opB       <= '0;
      mul_load      <= 1'b0;
      mul_step      <= 1'b0;
      busy          <= 1'b0;
      req.req_ready <= 1'b0;
      req.dataOut   <= '0;
      req.out_valid <= 1'b0;
`ifdef MUL_SIGNED_EN
      sgn           <= 1'b0;
`endif
    end else begin
      mul_load      <= 1'b0;
      req.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          req.req_ready <= 1'b1;
          if (req.req_valid && req.req_ready) begin
            case (req.Signal)
              F_MULTU: begin
                mul_opA       <= req.dataA;
                mul_opB       <= req.dataB;
                mul_load      <= 1'b1;
                busy          <= 1'b1;
                req.req_ready <= 1'b0;
                state         <= LOAD;
`ifdef MUL_SIGNED_EN
                sgn           <= 1'b0;
`endif
              end
`ifdef MUL_SIGNED_EN
              F_MULT: begin
                mul_opA       <= mag_a;
                mul_opB       <= mag_b;
                sgn           <= req.dataA[OP_W-1] ^ req.dataB[OP_W-1];
                mul_load      <= 1'b1;
                busy          <= 1'b1;
                req.req_ready <= 1'b0;
                state         <= LOAD;
              end
`else
              F_MULT: ;  // signed multiply not built: dropped like any unknown funct
`endif
              F_MFHI: begin
                req.dataOut   <= hi;
                req.out_valid <= 1'b1;
              end
              F_MFLO: begin
                req.dataOut   <= lo;
                req.out_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        LOAD: begin
          cnt      <= '0;
          mul_step <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          // Step stays high for exactly OP_W cycles, ending on the last count.
          if (cnt == CNT_LAST) begin
            mul_step <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
`ifdef MUL_SIGNED_EN
          {hi, lo} <= sgn ? (~mul_product + 1'b1) : mul_product;
`else
          {hi, lo} <= mul_product;
`endif
          busy          <= 1'b0;
          req.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed plus randomized bench for mul_sequencer; models the multiplier and HI/LO behaviourally.
module tb_mul_sequencer;
  localparam int OP_W = 32;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mul_load, mul_step, busy;
  logic [OP_W-1:0] mul_opA, mul_opB;
  logic [2*OP_W-1:0] mul_product;

  int checks = 0;
  int failures = 0;

  mul_sequencer_if #(.OP_W(OP_W)) bus ();

  mul_sequencer #(.OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .req(bus),
    .mul_load(mul_load), .mul_step(mul_step),
    .mul_opA(mul_opA), .mul_opB(mul_opB),
    .mul_product(mul_product), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product is only correct after exactly OP_W steps.
  logic [OP_W-1:0] ma = '0, mb = '0;
  int steps = 0;
  int loads = 0;
  int step_total = 0;
  logic force_en = 1'b0;
  logic [63:0] force_val = '0;

  always @(posedge clk) begin
    if (mul_load) begin
      ma <= mul_opA;
      mb <= mul_opB;
      steps <= 0;
      loads <= loads + 1;
    end else if (mul_step) begin
      steps <= steps + 1;
    end
    if (mul_step) step_total <= step_total + 1;
  end

  assign mul_product = (steps == OP_W) ? (force_en ? force_val : ({32'b0, ma} * {32'b0, mb}))
                                       : 64'hBAD0_BAD0_BAD0_BAD0;

  // Reference HI/LO
  logic [31:0] exp_hi = '0, exp_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int waits);
    bus.req_valid = 1'b1;
    bus.Signal = f;
    bus.dataA = a;
    bus.dataB = b;
    waits = 0;
    while (!bus.req_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) check("accept_timeout", 64'(waits), 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] f, input string tag);
    int w;
    logic [31:0] e;
    e = (f == F_MFHI) ? exp_hi : exp_lo;
    send(f, '0, '0, w);
    $display("txn read funct=%0d data=%h valid=%b", f, bus.dataOut, bus.out_valid);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.dataOut), 64'(e));
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_hold"}, 64'(bus.dataOut), 64'(e));
  endtask

  task automatic op_mul(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int w, low, l0, s0;
    bit is_mul, is_signed;
    logic [63:0] p;
    logic [31:0] ea, eb;
    is_signed = 1'b0;
`ifdef MUL_SIGNED_EN
    is_signed = (f == F_MULT);
`endif
    is_mul = (f == F_MULTU) || is_signed;
    l0 = loads;
    s0 = step_total;
    send(f, a, b, w);
    if (is_mul) begin
      ea = (is_signed && a[31]) ? -a : a;
      eb = (is_signed && b[31]) ? -b : b;
      check("opA", 64'(mul_opA), 64'(ea));
      check("opB", 64'(mul_opB), 64'(eb));
      check("busy_set", 64'(busy), 64'd1);
      low = 0;
      while (!bus.req_ready && low < 200) begin
        @(negedge clk);
        low++;
      end
      check("ready_low_cycles", 64'(low), 64'd34);
      check("load_pulses", 64'(loads - l0), 64'd1);
      check("step_pulses", 64'(step_total - s0), 64'(OP_W));
      check("busy_clear", 64'(busy), 64'd0);
      if (force_en) p = force_val;
      else if (is_signed) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else p = {32'b0, a} * {32'b0, b};
      {exp_hi, exp_lo} = p;
    end else begin
      check("dropped_ready", 64'(bus.req_ready), 64'd1);
      check("dropped_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("dropped_no_load", 64'(loads - l0), 64'd0);
    end
    $display("txn mul funct=%0d a=%h b=%h exp_hi=%h exp_lo=%h", f, a, b, exp_hi, exp_lo);
  endtask

  initial begin
    int w;
    logic [31:0] ra, rb;
    bus.req_valid = 1'b0;
    bus.Signal = '0;
    bus.dataA = '0;
    bus.dataB = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_load", 64'(mul_load), 64'd0);
    check("rst_step", 64'(mul_step), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_dout", 64'(bus.dataOut), 64'd0);
    check("rst_opA", 64'(mul_opA), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(bus.req_ready), 64'd1);
    rd(F_MFHI, "rst_hi");
    rd(F_MFLO, "rst_lo");

    // Largest unsigned operands
    op_mul(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("max_hi_const", 64'(exp_hi), 64'h0000_0000_FFFF_FFFE);
    rd(F_MFHI, "max_hi");
    rd(F_MFLO, "max_lo");

    // MFLO held while busy
    send(F_MULTU, 32'd7, 32'd6, w);
    send(F_MFLO, '0, '0, w);
    $display("txn held_mflo waits=%0d data=%h", w, bus.dataOut);
    check("held_waits", 64'(w), 64'd34);
    check("held_valid", 64'(bus.out_valid), 64'd1);
    check("held_data", 64'(bus.dataOut), 64'h2A);
    @(negedge clk);
    check("held_valid_drop", 64'(bus.out_valid), 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd42;

    // Known HI/LO, then back-to-back reads
    force_en = 1'b1;
    force_val = 64'h1234_5678_9ABC_DEF0;
    op_mul(F_MULTU, 32'd1, 32'd1);
    force_en = 1'b0;
    bus.req_valid = 1'b1;
    bus.Signal = F_MFHI;
    @(negedge clk);
    check("b2b_hi_valid", 64'(bus.out_valid), 64'd1);
    check("b2b_hi_data", 64'(bus.dataOut), 64'h1234_5678);
    bus.Signal = F_MFLO;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b_lo_valid", 64'(bus.out_valid), 64'd1);
    check("b2b_lo_data", 64'(bus.dataOut), 64'h9ABC_DEF0);
    @(negedge clk);
    check("b2b_valid_drop", 64'(bus.out_valid), 64'd0);
    check("b2b_hold", 64'(bus.dataOut), 64'h9ABC_DEF0);
    $display("txn back_to_back hi=%h lo=%h", exp_hi, exp_lo);

    // Unknown funct is dropped
    op_mul(6'd0, 32'd5, 32'd5);
    check("unk_no_valid", 64'(bus.out_valid), 64'd0);
    rd(F_MFHI, "unk_hi");
    rd(F_MFLO, "unk_lo");

    // Signed multiply (dropped without MUL_SIGNED_EN)
    op_mul(F_MULT, 32'hFFFF_FFFD, 32'd5);
    rd(F_MFHI, "mult_hi");
    rd(F_MFLO, "mult_lo");

    // Randomized multiplies
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'd0;
      op_mul(($urandom_range(0, 1) == 0) ? F_MULTU : F_MULT, ra, rb);
      rd(F_MFHI, "rnd_hi");
      rd(F_MFLO, "rnd_lo");
    end

    // Ensure HI/LO nonzero, then abort a multiply with reset
    op_mul(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5677);
    send(F_MULTU, 32'h0BAD_F00D, 32'h7777_7777, w);
    repeat (10) @(negedge clk);
    check("pre_abort_step", 64'(mul_step), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_ready", 64'(bus.req_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_step", 64'(mul_step), 64'd0);
    check("abort_load", 64'(mul_load), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    repeat (40) @(negedge clk);
    $display("txn reset_abort");
    rd(F_MFHI, "abort_hi");
    rd(F_MFLO, "abort_lo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
